pipe_seg: RTL and testbench

Parametrised pipeline segment register, the generic successor to the fixed per-stage segment registers between pipeline stages. Carries an arbitrary-width payload under a valid/ready handshake, so a stage can stall without a global enable. Supports a synchronous flush for exception/branch kill and an optional two-entry skid buffer that keeps `in_ready` fully registered. Includes a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_seg.sv | 150 +++++++++++++++
 tb/tb_pipe_seg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg.sv
// pipe_seg: valid/ready pipeline segment register with flush and a saturating stall counter.
// Define PIPE_SEG_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_seg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_SEG_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush kills everything; payload registers keep their contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_seg.sv
// Directed self-checking bench for pipe_seg (DATA_W=8, CNT_W=4).
module tb_pipe_seg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic       stall_clr = 1'b0;
  logic [3:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_seg #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_chk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Stream 1..8 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
      edge_chk();
      chk("stream_valid", out_valid, 1);
      chk($sformatf("stream_data_%0d", i), out_data, i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    edge_chk();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_keep_data", out_data, 8'h08);
    chk("stream_stall_cnt", stall_cnt, 0);

    // Backpressure with one beat held
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    #1;
    chk("bp_in_ready_empty", in_ready, 1);
    edge_chk();
    in_valid = 1'b0;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_occupancy", occupancy, 1);
`ifdef PIPE_SEG_SKID_EN
    chk("bp_in_ready_skid", in_ready, 1);
`else
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_ready, 1);
    out_ready = 1'b0;
    #1;
`endif

    // Stall counter saturation: edges 1..20 each see a stall
    for (int i = 0; i < 19; i++) edge_chk();
    chk("stall_mid_19", stall_cnt, 15);
    edge_chk();
    chk("stall_sat", stall_cnt, 15);
    chk("stall_data_held", out_data, 8'h55);
    @(negedge clk);
    stall_clr = 1'b1;
    edge_chk();
    chk("stall_clr", stall_cnt, 0);
    @(negedge clk);
    stall_clr = 1'b0;
    edge_chk();
    chk("stall_after_clr", stall_cnt, 1);

    // Flush with a simultaneous accept and deliver
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0D;
    edge_chk();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_data_kept", out_data, 8'h55);
    chk("flush_stall_cnt", stall_cnt, 1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    edge_chk();
    chk("flush_no_0d", out_valid, 0);

    // Asynchronous reset while in ONE
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    edge_chk();
    in_valid = 1'b0;
    chk("arst_pre_data", out_data, 8'h77);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h88;
    edge_chk();
    chk("post_rst_data", out_data, 8'h88);
    chk("post_rst_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    edge_chk();
    chk("post_rst_drain", out_valid, 0);

`ifdef PIPE_SEG_SKID_EN
    // Skid: A, B accepted under backpressure, C held upstream
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    edge_chk();
    chk("skid_a_occ", occupancy, 1);
    chk("skid_a_rdy", in_ready, 1);
    @(negedge clk);
    in_data = 8'h0B;
    edge_chk();
    chk("skid_two_occ", occupancy, 2);
    chk("skid_two_rdy", in_ready, 0);
    chk("skid_two_data", out_data, 8'h0A);
    @(negedge clk);
    in_data = 8'h0C;
    edge_chk();
    chk("skid_hold_occ", occupancy, 2);
    chk("skid_hold_data", out_data, 8'h0A);
    @(negedge clk);
    out_ready = 1'b1;
    edge_chk();
    chk("skid_rel_b", out_data, 8'h0B);
    chk("skid_rel_occ", occupancy, 1);
    chk("skid_rel_rdy", in_ready, 1);
    edge_chk();
    chk("skid_rel_c", out_data, 8'h0C);
    chk("skid_rel_c_occ", occupancy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    edge_chk();
    chk("skid_rel_empty", out_valid, 0);
    chk("skid_rel_keep", out_data, 8'h0C);

    // Flush from TWO with 0xD pending
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    edge_chk();
    @(negedge clk);
    in_data = 8'h02;
    edge_chk();
    chk("skid_fl_occ2", occupancy, 2);
    @(negedge clk);
    in_data = 8'h0D;
    flush   = 1'b1;
    edge_chk();
    chk("skid_fl_valid", out_valid, 0);
    chk("skid_fl_occ", occupancy, 0);
    chk("skid_fl_rdy", in_ready, 1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    edge_chk();
    chk("skid_fl_no_0d", out_valid, 0);
    chk("skid_fl_data", out_data, 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
